// File: rtl/flare_qualifier.sv
// Conditions the asynchronous LM393 comparator output into a qualified flare level,
// with edge pulses and a saturating flare counter.
module flare_qualifier #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned ON_COUNT   = 8,
  parameter int unsigned OFF_COUNT  = 32,
  parameter int unsigned MIN_HOLD   = 500,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_in,
  input  logic             enable,
  input  logic             clear_count,
  output logic             flare_detect,
  output logic             flare_rise,
  output logic             flare_fall,
  output logic [CNT_W-1:0] event_count,
  output logic [1:0]       q_state
);

  localparam int unsigned DivW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned RunMax = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int unsigned RunW   = $clog2(RunMax + 1);
  localparam int unsigned HoldW  = $clog2(MIN_HOLD + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
  localparam logic [RunW-1:0]  RunOn    = RunW'(ON_COUNT);
  localparam logic [RunW-1:0]  RunOff   = RunW'(OFF_COUNT);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(MIN_HOLD);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StArming    = 2'd1;
  localparam logic [1:0] StActive    = 2'd2;
  localparam logic [1:0] StReleasing = 2'd3;

  logic             sync1_q, sync2_q;
  logic [DivW-1:0]  div_q, div_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [1:0]       state_q, state_d;
  logic             detect_q, detect_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s;
  logic             tick;

  // Two-flop synchronizer for the asynchronous comparator pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign s    = sync2_q;
  assign tick = enable && (div_q == DivLast);

  always_comb begin
    div_d   = div_q;
    run_d   = run_q;
    hold_d  = hold_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (!enable) begin
      // Disabling aborts any flare; the fall pulse still marks a dropped level.
      div_d   = '0;
      run_d   = '0;
      hold_d  = '0;
      state_d = StIdle;
      fall_d  = detect_q;
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        case (state_q)
          StIdle: begin
            if (s) begin
              state_d = StArming;
              run_d   = RunW'(1);
            end
          end
          StArming: begin
            if (!s) begin
              state_d = StIdle;
              run_d   = '0;
            end else if ((run_q + RunW'(1)) == RunOn) begin
              state_d = StActive;
              run_d   = '0;
              hold_d  = '0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end
          StActive: begin
            if (hold_q < HoldSat) begin
              hold_d = hold_q + HoldW'(1);
            end else if (!s) begin
              state_d = StReleasing;
              run_d   = RunW'(1);
            end
          end
          StReleasing: begin
            // Returning to ACTIVE keeps hold saturated so release can restart at once.
            if (s) begin
              state_d = StActive;
              run_d   = '0;
            end else if ((run_q + RunW'(1)) == RunOff) begin
              state_d = StIdle;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end
          default: begin
            state_d = StIdle;
            run_d   = '0;
          end
        endcase
      end
    end

    detect_d = (state_d == StActive) || (state_d == StReleasing);
  end

  // Clear takes effect first so a coincident rise leaves the count at one.
  always_comb begin
    count_d = count_q;
    if (clear_count) begin
      count_d = '0;
    end
    if (rise_d && !(&count_d)) begin
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      run_q    <= '0;
      hold_q   <= '0;
      state_q  <= StIdle;
      detect_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      div_q    <= div_d;
      run_q    <= run_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      detect_q <= detect_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      count_q  <= count_d;
    end
  end

  assign flare_detect = detect_q;
  assign flare_rise   = rise_q;
  assign flare_fall   = fall_q;
  assign event_count  = count_q;
  assign q_state      = state_q;

endmodule
